// File: rtl/status_serial_rx.sv
// Receiver for the alarm status link: deserializes 4-bit LSB-first frames, validates them
// and runs a link-loss watchdog. Optional output status_changed under STATUS_RX_CHANGE_IRQ_EN.
module status_serial_rx #(
   parameter int MSG_W        = 4,
   parameter int MIN_SB       = 3,
   parameter int LINK_TIMEOUT = 64
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             STATUS_IN,
   input  logic             STATUS_RECV,
   output logic [MSG_W-1:0] status,
   output logic             armed,
   output logic             alarm,
   output logic             sensor1,
   output logic             sensor2,
   output logic             frame_valid,
   output logic             frame_err,
`ifdef STATUS_RX_CHANGE_IRQ_EN
   output logic             status_changed,
`endif
   output logic             link_lost
);

   localparam int BIT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
   localparam int GAP_W = $clog2(MIN_SB + 1);
   localparam int WD_W  = $clog2(LINK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_e;

   state_e           state_q, state_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [MSG_W-2:0] shreg_q, shreg_d;
   logic [MSG_W-1:0] status_q, status_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic             frame_valid_q, frame_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             link_lost_q, link_lost_d;
   logic [MSG_W-1:0] frame;
   logic             frame_legal;
`ifdef STATUS_RX_CHANGE_IRQ_EN
   logic             status_changed_q, status_changed_d;
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      shreg_d       = shreg_q;
      status_d      = status_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      frame         = {STATUS_IN, shreg_q};
      // An armed-less alarm cannot come from a healthy transmitter.
      frame_legal   = !(frame[1] && !frame[0]);
      wd_cnt_d      = (wd_cnt_q == WD_W'(LINK_TIMEOUT)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);

      case (state_q)
         IDLE: begin
            if (STATUS_RECV) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (STATUS_RECV) begin
               // The aborting strobe doubles as the start of the next frame.
               frame_err_d = 1'b1;
               bit_cnt_d   = '0;
            end else if (bit_cnt_q == BIT_W'(MSG_W - 1)) begin
               state_d   = GAP;
               gap_cnt_d = '0;
               if (frame_legal) begin
                  status_d      = frame;
                  frame_valid_d = 1'b1;
                  wd_cnt_d      = '0;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               for (int i = 0; i < MSG_W - 1; i++) begin
                  if (bit_cnt_q == BIT_W'(i)) shreg_d[i] = STATUS_IN;
               end
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         GAP: begin
            if (STATUS_RECV) begin
               frame_err_d = 1'b1;
               state_d     = SHIFT;
               bit_cnt_d   = '0;
            end else if (gap_cnt_q == GAP_W'(MIN_SB - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Using the next count lets a valid frame clear link_lost in the same cycle as frame_valid.
      link_lost_d = (wd_cnt_d == WD_W'(LINK_TIMEOUT));

`ifdef STATUS_RX_CHANGE_IRQ_EN
      status_changed_d = frame_valid_d && (frame != status_q);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         gap_cnt_q     <= '0;
         shreg_q       <= '0;
         status_q      <= '0;
         wd_cnt_q      <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         link_lost_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         shreg_q       <= shreg_d;
         status_q      <= status_d;
         wd_cnt_q      <= wd_cnt_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         link_lost_q   <= link_lost_d;
      end
   end

`ifdef STATUS_RX_CHANGE_IRQ_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) status_changed_q <= 1'b0;
      else     status_changed_q <= status_changed_d;
   end

   assign status_changed = status_changed_q;
`endif

   assign status      = status_q;
   assign armed       = status_q[0];
   assign alarm       = status_q[1];
   assign sensor1     = status_q[2];
   assign sensor2     = status_q[3];
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign link_lost   = link_lost_q;

endmodule

// File: tb/tb_status_serial_rx.sv
// Directed self-checking bench for status_serial_rx; define STATUS_RX_CHANGE_IRQ_EN to
// also check status_changed.
module tb_status_serial_rx;

   logic       CLK;
   logic       RST;
   logic       STATUS_IN;
   logic       STATUS_RECV;
   logic [3:0] status;
   logic       armed, alarm, sensor1, sensor2;
   logic       frame_valid, frame_err, link_lost;
`ifdef STATUS_RX_CHANGE_IRQ_EN
   logic       status_changed;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   status_serial_rx dut (
      .CLK           (CLK),
      .RST           (RST),
      .STATUS_IN     (STATUS_IN),
      .STATUS_RECV   (STATUS_RECV),
      .status        (status),
      .armed         (armed),
      .alarm         (alarm),
      .sensor1       (sensor1),
      .sensor2       (sensor2),
      .frame_valid   (frame_valid),
      .frame_err     (frame_err),
`ifdef STATUS_RX_CHANGE_IRQ_EN
      .status_changed(status_changed),
`endif
      .link_lost     (link_lost)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_bits(input logic [3:0] f);
      STATUS_RECV = 1'b0;
      for (int k = 0; k < 4; k++) begin
         STATUS_IN = f[k];
         tick();
      end
      STATUS_IN = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] f);
      STATUS_RECV = 1'b1;
      tick();
      send_bits(f);
   endtask

   initial begin
      RST         = 1'b0;
      STATUS_IN   = 1'b0;
      STATUS_RECV = 1'b0;
      #2 RST = 1'b1;
      idle(3);
      RST = 1'b0;
      tick();
      check("rst_status", 32'(status), 32'h0);
      check("rst_valid", 32'(frame_valid), 32'h0);
      check("rst_err", 32'(frame_err), 32'h0);
      check("rst_lost", 32'(link_lost), 32'h0);

      // Legal frame 0001
      send_frame(4'b0001);
      check("f1_valid", 32'(frame_valid), 32'h1);
      check("f1_status", 32'(status), 32'h1);
      check("f1_armed", 32'(armed), 32'h1);
      check("f1_err", 32'(frame_err), 32'h0);
`ifdef STATUS_RX_CHANGE_IRQ_EN
      check("f1_changed", 32'(status_changed), 32'h1);
`endif
      tick();
      check("f1_valid_pulse", 32'(frame_valid), 32'h0);
      idle(2);

      // Illegal frame 0010: alarm without armed
      send_frame(4'b0010);
      check("ill_err", 32'(frame_err), 32'h1);
      check("ill_valid", 32'(frame_valid), 32'h0);
      check("ill_status", 32'(status), 32'h1);
      tick();
      check("ill_err_pulse", 32'(frame_err), 32'h0);
      idle(2);

      // Strobe during bit 2 aborts, then 1011 follows from that strobe
      STATUS_RECV = 1'b1;
      tick();
      STATUS_RECV = 1'b0;
      STATUS_IN   = 1'b1;
      tick();
      tick();
      STATUS_RECV = 1'b1;
      tick();
      check("abort_err", 32'(frame_err), 32'h1);
      check("abort_status", 32'(status), 32'h1);
      send_bits(4'b1011);
      check("abort_valid", 32'(frame_valid), 32'h1);
      check("abort_noerr", 32'(frame_err), 32'h0);
      check("abort_status2", 32'(status), 32'hB);
      check("abort_flags", 32'({sensor2, sensor1, alarm, armed}), 32'hB);

      // Early strobe one cycle after the frame end
      STATUS_RECV = 1'b1;
      tick();
      check("early_err", 32'(frame_err), 32'h1);
      check("early_valid", 32'(frame_valid), 32'h0);
      send_bits(4'b0011);
      check("early_valid2", 32'(frame_valid), 32'h1);
      check("early_status", 32'(status), 32'h3);

      // Watchdog: link_lost rises exactly 64 cycles after the last valid frame
      idle(63);
      check("wd_before", 32'(link_lost), 32'h0);
      tick();
      check("wd_lost", 32'(link_lost), 32'h1);
      idle(5);
      check("wd_hold", 32'(link_lost), 32'h1);
      send_frame(4'b0101);
      check("wd_valid", 32'(frame_valid), 32'h1);
      check("wd_cleared", 32'(link_lost), 32'h0);
      check("wd_status", 32'(status), 32'h5);
      idle(3);

      // Reset during bit 1 of a frame
      STATUS_RECV = 1'b1;
      tick();
      STATUS_RECV = 1'b0;
      STATUS_IN   = 1'b1;
      tick();
      RST = 1'b1;
      #2;
      check("mid_rst_status", 32'(status), 32'h0);
      check("mid_rst_flags", 32'({frame_valid, frame_err, link_lost}), 32'h0);
      #3 RST = 1'b0;
      STATUS_IN = 1'b0;
      tick();
      check("post_rst_status", 32'(status), 32'h0);
      send_frame(4'b0001);
      check("post_rst_valid", 32'(frame_valid), 32'h1);
      check("post_rst_status2", 32'(status), 32'h1);
`ifdef STATUS_RX_CHANGE_IRQ_EN
      check("chg_first", 32'(status_changed), 32'h1);
      idle(3);
      send_frame(4'b0001);
      check("chg_repeat_valid", 32'(frame_valid), 32'h1);
      check("chg_repeat", 32'(status_changed), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
